// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states, mode encodings and the byte-level AES
// transforms (S-box, row shifts, column mixing, key-schedule helpers).
package aes_pkg;

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} aesState_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam int   BLOCK_W  = 128;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, same layout.
  localparam logic [0:2047] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Key-schedule round constants for rcon(1)..rcon(10).
  localparam logic [0:79] RCON_TBL = 80'h01020408102040801b36;

  function automatic bit nkNrLegal(input int nk, input int nr);
    return ((nk == 4) || (nk == 6) || (nk == 8)) && (nr == nk + 6);
  endfunction

  // Encrypt walks the schedule upwards, decrypt walks it downwards.
  function automatic int roundKeyIdx(input logic mode, input int r, input int nr);
    return (mode == MODE_DEC) ? (nr - r) : r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return INV_SBOX_TBL[8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input int j);
    return RCON_TBL[8*(j-1) +: 8];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte i of the block sits at row i%4, column i/4.
  function automatic logic [0:127] subBytes(input logic [0:127] s);
    logic [0:127] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [0:127] invSubBytes(input logic [0:127] s);
    logic [0:127] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = invSbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [0:127] shiftRows(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] invShiftRows(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*((c+r)%4)) +: 8] = s[8*(r+4*c) +: 8];
    return o;
  endfunction

  // Circulant column multiply; m holds the first matrix row, byte 0 first.
  function automatic logic [0:127] mixCols(input logic [0:127] s, input logic [0:31] m);
    logic [0:127] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gfMul(s[8*(4*c+j) +: 8], m[8*((j-k) & 3) +: 8]);
        o[8*(4*c+k) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [0:127] mixColumns(input logic [0:127] s);
    return mixCols(s, 32'h02030101);
  endfunction

  function automatic logic [0:127] invMixColumns(input logic [0:127] s);
    return mixCols(s, 32'h0e0b0d09);
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// aes_round_unit: one combinational AES round in either direction; the
// final round skips the column mixing step.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] state_i,
  input  logic [0:BLOCK_W-1] roundKey_i,
  input  logic               mode_i,
  input  logic               finalRound_i,
  output logic [0:BLOCK_W-1] nextState_o
);

  logic [0:BLOCK_W-1] encCore;
  logic [0:BLOCK_W-1] decCore;

  // Forward round mixes before the key add, inverse round mixes after it.
  always_comb begin
    encCore = shiftRows(subBytes(state_i));
    decCore = invSubBytes(invShiftRows(state_i)) ^ roundKey_i;
    if (mode_i == MODE_ENC) begin
      nextState_o = (finalRound_i ? encCore : mixColumns(encCore)) ^ roundKey_i;
    end else begin
      nextState_o = finalRound_i ? decCore : invMixColumns(decCore);
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 engine, one round per clock,
// start/busy/done handshake, operands latched at start.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [0:BLOCK_W-1] data_in,
  input  logic [0:32*NK-1]   key,
  output logic               busy,
  output logic               done,
  output logic [0:BLOCK_W-1] data_out
);

  localparam int RW     = $clog2(NR + 1);
  localparam int NWORDS = 4 * (NR + 1);
  localparam int RK_W   = BLOCK_W * (NR + 1);

  if (!nkNrLegal(NK, NR)) begin : gIllegalConfig
    $error("aes_iter_core: NR must equal NK+6 with NK in {4,6,8}");
  end

  aesState_e          state_q, state_d;
  logic [RW-1:0]      round_q, round_d;
  logic               mode_q, mode_d;
  logic [0:BLOCK_W-1] data_q, data_d;
  logic [0:32*NK-1]   key_q, key_d;
  logic [0:BLOCK_W-1] block_q, block_d;
  logic [0:BLOCK_W-1] dataOut_q, dataOut_d;
  logic               done_q, done_d;

  logic               acceptStart, loadInit, loadRound, loadFinal;
  logic [0:RK_W-1]    roundKeys;
  logic [0:BLOCK_W-1] roundKey;
  logic [0:BLOCK_W-1] roundOut;
  int                 rkIdx;

  // Full key schedule; round key k occupies bits [128k +: 128].
  function automatic logic [0:RK_W-1] keyExpansion(input logic [0:32*NK-1] k);
    logic [31:0]     w [NWORDS];
    logic [31:0]     temp;
    logic [0:RK_W-1] rks;
    for (int i = 0; i < NK; i++) begin
      w[i] = k[32*i +: 32];
      rks[32*i +: 32] = w[i];
    end
    for (int i = NK; i < NWORDS; i++) begin
      temp = w[i-1];
      if (i % NK == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rcon(i / NK), 24'h000000};
      end else if ((NK > 6) && (i % NK == 4)) begin
        temp = subWord(temp);
      end
      w[i] = w[i-NK] ^ temp;
      rks[32*i +: 32] = w[i];
    end
    return rks;
  endfunction

  // Round key for the current step, taken from the latched key only.
  always_comb begin
    roundKeys = keyExpansion(key_q);
    rkIdx     = roundKeyIdx(mode_q, int'(round_q), NR);
    roundKey  = roundKeys[BLOCK_W*rkIdx +: BLOCK_W];
  end

  aes_round_unit uRound (
    .state_i      (block_q),
    .roundKey_i   (roundKey),
    .mode_i       (mode_q),
    .finalRound_i (state_q == FINAL),
    .nextState_o  (roundOut)
  );

  // FSM state register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> INIT -> ROUND x (NR-1) -> FINAL -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (round_q == RW'(NR - 1)) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes and the busy flag.
  always_comb begin
    acceptStart = 1'b0;
    loadInit    = 1'b0;
    loadRound   = 1'b0;
    loadFinal   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy        = 1'b0;
        acceptStart = start;
      end
      INIT:    loadInit  = 1'b1;
      ROUND:   loadRound = 1'b1;
      FINAL:   loadFinal = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Datapath next values: operand latch, round state, counter, result.
  always_comb begin
    mode_d    = mode_q;
    data_d    = data_q;
    key_d     = key_q;
    block_d   = block_q;
    dataOut_d = dataOut_q;
    round_d   = round_q;
    done_d    = 1'b0;
    if (acceptStart) begin
      mode_d  = mode;
      data_d  = data_in;
      key_d   = key;
      round_d = '0;
    end
    if (loadInit) begin
      block_d = data_q ^ roundKey;
      round_d = RW'(1);
    end
    if (loadRound) begin
      block_d = roundOut;
      round_d = round_q + RW'(1);
    end
    if (loadFinal) begin
      dataOut_d = roundOut;
      done_d    = 1'b1;
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q   <= '0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      key_q     <= '0;
      block_q   <= '0;
      dataOut_q <= '0;
      done_q    <= 1'b0;
    end else begin
      round_q   <= round_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      key_q     <= key_d;
      block_q   <= block_d;
      dataOut_q <= dataOut_d;
      done_q    <= done_d;
    end
  end

  assign done     = done_q;
  assign data_out = dataOut_q;

endmodule
